// File: rtl/multi_button_debouncer.sv
// Multi-channel push-button debouncer with edge, long-press and auto-repeat pulses.
// One shared sample tick drives a per-channel shift-register filter with hysteresis.
module multi_button_debouncer #(
    parameter int NUM_BTN   = 4,
    parameter int CLK_HZ    = 100_000_000,
    parameter int SAMPLE_HZ = 1000,
    parameter int DEPTH     = 8,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] i_btn,
    output logic [NUM_BTN-1:0] o_level,
    output logic [NUM_BTN-1:0] o_rise,
    output logic [NUM_BTN-1:0] o_fall,
    output logic [NUM_BTN-1:0] o_both,
    output logic [NUM_BTN-1:0] o_long,
    output logic [NUM_BTN-1:0] o_repeat
);
    localparam int DIV          = CLK_HZ / SAMPLE_HZ;
    localparam int LONG_TICKS   = LONG_MS * SAMPLE_HZ / 1000;
    localparam int REPEAT_TICKS = REPEAT_MS * SAMPLE_HZ / 1000;
    localparam int CNT_W        = $clog2(DIV);
    localparam int HOLD_W       = $clog2(LONG_TICKS + 1);
    localparam int REP_W        = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

    logic [CNT_W-1:0]   div_q, div_d;
    logic               tick;
    logic [NUM_BTN-1:0] sync1_q, sync2_q;

    assign tick  = (div_q == CNT_W'(DIV - 1));
    assign div_d = tick ? '0 : div_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            div_q   <= div_d;
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_ch
            logic [DEPTH-1:0]  sr_q, sr_d;
            logic              level_q, level_d;
            logic              level_prev_q;
            logic [HOLD_W-1:0] hold_q, hold_d;
            logic              long_q, long_d;
            logic              hold_full;

            assign hold_full = (hold_q == HOLD_W'(LONG_TICKS));

            always_comb begin
                sr_d    = sr_q;
                level_d = level_q;
                hold_d  = '0;
                long_d  = 1'b0;
                if (tick) begin
                    sr_d = {sync2_q[gi], sr_q[DEPTH-1:1]};
                end
                // Level only moves on a unanimous window; mixed windows hold it.
                if (&sr_q) begin
                    level_d = 1'b1;
                end else if (~|sr_q) begin
                    level_d = 1'b0;
                end
                if (level_q) begin
                    hold_d = hold_q;
                    if (tick && !hold_full) begin
                        hold_d = hold_q + HOLD_W'(1);
                        long_d = (hold_q == HOLD_W'(LONG_TICKS - 1));
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sr_q         <= '0;
                    level_q      <= 1'b0;
                    level_prev_q <= 1'b0;
                    hold_q       <= '0;
                    long_q       <= 1'b0;
                end else begin
                    sr_q         <= sr_d;
                    level_q      <= level_d;
                    level_prev_q <= level_q;
                    hold_q       <= hold_d;
                    long_q       <= long_d;
                end
            end

            assign o_level[gi] = level_q;
            assign o_rise[gi]  = level_q & ~level_prev_q;
            assign o_fall[gi]  = ~level_q & level_prev_q;
            assign o_both[gi]  = o_rise[gi] | o_fall[gi];
            // Gating with level suppresses a pulse landing on the release cycle.
            assign o_long[gi]  = long_q & level_q;

            if (REPEAT_TICKS > 0) begin : g_rep
                logic [REP_W-1:0] rep_q, rep_d;
                logic             rep_hit;

                assign rep_hit = (rep_q == REP_W'(REPEAT_TICKS));

                always_comb begin
                    rep_d = '0;
                    if (level_q && !rep_hit) begin
                        rep_d = rep_q;
                        if (tick && hold_full) begin
                            rep_d = rep_q + REP_W'(1);
                        end
                    end
                end

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        rep_q <= '0;
                    end else begin
                        rep_q <= rep_d;
                    end
                end

                assign o_repeat[gi] = level_q & rep_hit;
            end else begin : g_norep
                assign o_repeat[gi] = 1'b0;
            end
        end
    endgenerate
endmodule

// File: doc/multi_button_debouncer.md
MULTI_BUTTON_DEBOUNCER -- requirements
Module: multi_button_debouncer

Interface
REQ-001 Parameter NUM_BTN, default 4, number of independent button channels (>=1).
REQ-002 Parameter CLK_HZ, default 100_000_000, clk frequency in Hz.
REQ-003 Parameter SAMPLE_HZ, default 1000, debounce sampling rate; DIV = CLK_HZ/SAMPLE_HZ, must be >=2.
REQ-004 Parameter DEPTH, default 8, samples per channel shift register (>=2).
REQ-005 Parameter LONG_MS, default 1000, hold time before long-press pulse; LONG_TICKS = LONG_MS*SAMPLE_HZ/1000, must be >=1.
REQ-006 Parameter REPEAT_MS, default 200, auto-repeat period after long press; REPEAT_TICKS = REPEAT_MS*SAMPLE_HZ/1000; 0 disables repeat.
REQ-007 clk  input  1  system clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 i_btn  input  NUM_BTN  raw asynchronous button inputs, bit n = channel n, 1 = pressed.
REQ-010 o_level  output  NUM_BTN  debounced button level per channel.
REQ-011 o_rise  output  NUM_BTN  one-clk pulse on debounced press.
REQ-012 o_fall  output  NUM_BTN  one-clk pulse on debounced release.
REQ-013 o_both  output  NUM_BTN  o_rise | o_fall, per bit.
REQ-014 o_long  output  NUM_BTN  one-clk pulse when press held LONG_TICKS ticks.
REQ-015 o_repeat  output  NUM_BTN  one-clk pulse every REPEAT_TICKS ticks after o_long while still held.

Function
REQ-016 Single shared tick generator: counter 0..DIV-1, width $clog2(DIV); tick asserted for one clk when counter == DIV-1, counter then wraps to 0.
REQ-017 Each i_btn bit passes a 2-flop synchronizer before any other use.
REQ-018 On each tick, per-channel shift register shifts right, synchronized sample entering MSB; unchanged on non-tick cycles.
REQ-019 Hysteresis: level register set to 1 on the clk after shift register becomes all ones, cleared to 0 on the clk after it becomes all zeros, otherwise holds.
REQ-020 Delayed copy level_d registered every clk; o_rise = level & ~level_d, o_fall = ~level & level_d; each exactly one clk wide.
REQ-021 Press latency from stable i_btn change: 2 clk sync + DEPTH ticks + 1 clk to o_level, o_rise coincident with o_level rising.
REQ-022 Hold counter (width $clog2(LONG_TICKS+1)) increments on each tick while o_level=1; saturates at LONG_TICKS.
REQ-023 o_long pulses one clk on the cycle after hold counter transitions to LONG_TICKS; at most once per press.
REQ-024 After o_long, repeat counter increments on each tick while held; on reaching REPEAT_TICKS, o_repeat pulses one clk and counter returns to 0.
REQ-025 REPEAT_TICKS = 0: o_repeat constantly 0, repeat counter logic removed.
REQ-026 o_level=0 clears hold and repeat counters the next clk; no o_long/o_repeat pulse in or after release cycle.
REQ-027 Release shorter than DEPTH ticks of zeros (bounce) leaves o_level, counters and pulses unaffected.
REQ-028 Channels fully independent; simultaneous events on several channels produce simultaneous per-bit pulses.
REQ-029 o_rise and o_long on same channel never coincide (LONG_TICKS>=1 guarantees separation).

Reset
REQ-030 Reset clears tick counter, synchronizers, shift registers, level, level_d, hold/repeat counters; all outputs 0 while reset asserted.
REQ-031 Reset mid-press: outputs 0 immediately; after release, no o_fall pulse generated; a still-held button produces a fresh o_rise after full latency.
REQ-032 Reset deassertion takes effect on next clk edge; first tick occurs DIV clks later.

Verification (CLK_HZ=1000, SAMPLE_HZ=100, DIV=10, DEPTH=4, LONG_TICKS=10, REPEAT_TICKS=5, NUM_BTN=4)
REQ-033 i_btn[0]=1 held stable -> o_level[0] rises and o_rise[0] pulses 1 clk within 2+4*10+1 clks; o_long[0] after 10 further ticks; o_repeat[0] every 50 clks thereafter.
REQ-034 i_btn[1] toggling every 15 clks for 200 clks -> o_level[1], o_rise[1], o_fall[1] remain 0.
REQ-035 Held channel 2, then 2-tick glitch to 0 -> no o_fall[2], o_level[2] stays 1, long timing unaffected.
REQ-036 Press released after 7 ticks -> o_fall pulses once, no o_long ever.
REQ-037 Channels 0 and 3 pressed same clk -> o_rise = 4'b1001 in one cycle.
REQ-038 Reset asserted during repeat phase -> all outputs 0 next clk; input still high -> new o_rise after full latency, no o_fall.
